// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I execute-stage ALU with optional iterative mul/div engine (ALU_MEXT_EN)
module alu_exec_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SH_W = $clog2(XLEN);

    if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0 || CNT_W != $clog2(XLEN) + 1) begin : g_param_check
        $error("alu_exec_unit: XLEN must be a power of two >= 8 and CNT_W is derived");
    end

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILL, OP_M
    } op_e;

`ifdef ALU_MEXT_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_e;
`endif

    state_e          state;
    op_e             op;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [SH_W-1:0] shamt;

    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        op   = OP_ILL;
        op_b = alu_src ? imm : rs2;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                op_b = rs2;
                if (func7 == 7'b0000000) begin
                    op = base_op(func3);
                end else if (func7 == 7'b0100000) begin
                    if (func3 == 3'b000)      op = OP_SUB;
                    else if (func3 == 3'b101) op = OP_SRA;
                end
`ifdef ALU_MEXT_EN
                else if (func7 == 7'b0000001) begin
                    op = OP_M;
                end
`endif
            end
            default: begin
                // Immediate forms: func7 is only meaningful for the shifts
                if (func3 == 3'b001) begin
                    if (func7 == 7'b0000000) op = OP_SLL;
                end else if (func3 == 3'b101) begin
                    if (func7 == 7'b0000000)      op = OP_SRL;
                    else if (func7 == 7'b0100000) op = OP_SRA;
                end else begin
                    op = base_op(func3);
                end
            end
        endcase
    end

    assign shamt = op_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rs1 + op_b;
            OP_SUB:  alu_res = rs1 - op_b;
            OP_SLL:  alu_res = rs1 << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1 < op_b};
            OP_XOR:  alu_res = rs1 ^ op_b;
            OP_SRL:  alu_res = rs1 >> shamt;
            OP_SRA:  alu_res = XLEN'($signed(rs1) >>> shamt);
            OP_OR:   alu_res = rs1 | op_b;
            OP_AND:  alu_res = rs1 & op_b;
            default: alu_res = '0;
        endcase
    end

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);

`ifdef ALU_MEXT_EN
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        m_f3;
    logic [XLEN-1:0]   acc_hi, acc_lo, b_mag;
    logic              neg_q, neg_r, b_zero;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag_in, b_mag_in;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, m_res;

    // MUL/MULH/DIV/REM treat A as signed; MULH/DIV/REM also B
    assign a_signed = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    assign b_signed = func3[2] ? ~func3[0] : ~func3[1];
    assign a_neg    = a_signed & rs1[XLEN-1];
    assign b_neg    = b_signed & op_b[XLEN-1];
    assign a_mag_in = a_neg ? -rs1 : rs1;
    assign b_mag_in = b_neg ? -op_b : op_b;

    // acc_hi:acc_lo is the product for multiply, remainder:quotient for divide
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
    assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge   = div_sh >= {1'b0, b_mag};
    assign div_diff = div_sh - {1'b0, b_mag};

    assign prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo_s  = b_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_s  = neg_r ? -acc_hi : acc_hi;

    always_comb begin
        case (m_f3)
            3'b000:                 m_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: m_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         m_res = quo_s;
            default:                m_res = rem_s;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_MEXT_EN
            cnt    <= '0;
            m_f3   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            b_mag  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
`endif
        end else if (in_valid && in_ready) begin
`ifdef ALU_MEXT_EN
            if (op == OP_M) begin
                state     <= RUN;
                out_valid <= 1'b0;
                cnt       <= CNT_W'(XLEN);
                m_f3      <= func3;
                acc_hi    <= '0;
                acc_lo    <= a_mag_in;
                b_mag     <= b_mag_in;
                neg_q     <= a_neg ^ b_neg;
                neg_r     <= a_neg;
                b_zero    <= (op_b == '0);
            end else
`endif
            begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
                illegal   <= (op == OP_ILL);
            end
        end else begin
            case (state)
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_MEXT_EN
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        if (m_f3[2]) begin
                            acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[XLEN:1];
                            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                        end
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= m_res;
                        zero      <= (m_res == '0);
                        illegal   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule
